// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and strobe sequencer for the
// 64-bit strobe-clocked RAM. One transaction at a time; owns the RAM
// data-bus turnaround so this block never drives while the RAM might.
module mem_arbiter #(
  parameter int unsigned ADDR_LIMIT_BITS = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [63:0] d_rdata,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [63:0] ram_addr,
  inout  logic [63:0] ram_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_SET,
    S_TURN_STB,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [63:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        ram_drives_q, ram_drives_d;
  logic [63:0] i_rdata_q, i_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;

  logic        sel_port;
  logic [63:0] sel_addr;
  logic        sel_we;
  logic        sel_oor;
  logic        data_drive;

  // Request selection: single pending request wins, otherwise round-robin
  always_comb begin
    sel_port = PORT_I;
    if (i_req && d_req) begin
      sel_port = ~last_grant_q;
    end else if (d_req) begin
      sel_port = PORT_D;
    end
    sel_addr = (sel_port == PORT_D) ? d_addr : i_addr;
    sel_we   = (sel_port == PORT_D) ? d_we : 1'b0;
    sel_oor  = (sel_addr >> ADDR_LIMIT_BITS) != '0;
  end

  // Next-state and transaction bookkeeping
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    ram_drives_d = ram_drives_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d = sel_port;
          addr_d  = sel_addr;
          we_d    = sel_we;
          wdata_d = d_wdata;
          err_d   = sel_oor;
          if (sel_oor) begin
            state_d = S_RESP;
          end else if (sel_we && ram_drives_q) begin
            state_d = S_TURN_SET;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_TURN_SET: state_d = S_TURN_STB;
      S_TURN_STB: begin
        ram_drives_d = 1'b0;
        state_d      = S_SETUP;
      end
      S_SETUP: state_d = S_STROBE;
      S_STROBE: begin
        ram_drives_d = ~we_q;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (!we_q) begin
          if (grant_q == PORT_D) begin
            d_rdata_d = ram_data;
          end else begin
            i_rdata_d = ram_data;
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM strobes, bus drive enable and completion pulses decoded from state
  always_comb begin
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_oe     = 1'b0;
    data_drive = 1'b0;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    i_err      = 1'b0;
    d_err      = 1'b0;
    case (state_q)
      S_TURN_SET: ram_we = 1'b1;
      S_TURN_STB: begin
        ram_we = 1'b1;
        ram_cs = 1'b1;
      end
      S_SETUP, S_HOLD: begin
        ram_we     = we_q;
        ram_oe     = ~we_q;
        data_drive = we_q && (state_q == S_SETUP);
      end
      S_STROBE: begin
        ram_we     = we_q;
        ram_oe     = ~we_q;
        ram_cs     = 1'b1;
        data_drive = we_q;
      end
      S_RESP: begin
        if (grant_q == PORT_D) begin
          d_ack = 1'b1;
          d_err = err_q;
        end else begin
          i_ack = 1'b1;
          i_err = err_q;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_D;
      grant_q      <= PORT_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      ram_drives_q <= 1'b1;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      ram_drives_q <= ram_drives_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign ram_addr = addr_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign ram_data = data_drive ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a strobe-clocked RAM model and an
// expectation queue checked as each ack appears.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [63:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [63:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_ack, d_err;
  logic [63:0] d_rdata;
  logic        ram_cs, ram_we, ram_oe;
  logic [63:0] ram_addr;
  wire  [63:0] ram_data;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_LIMIT_BITS(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_data(ram_data)
  );

  // RAM device: acts on rising cs, keeps driving read data until a write strobe
  logic [63:0] ram_mem [logic [63:0]];
  logic        ram_drv = 1'b1;
  logic [63:0] ram_dout = '0;
  int unsigned cs_count = 0;
  assign ram_data = ram_drv ? ram_dout : 'z;

  always @(posedge ram_cs) begin
    cs_count++;
    if (ram_we) begin
      ram_mem[ram_addr] = ram_data;
      ram_drv = 1'b0;
    end else begin
      ram_dout = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : '0;
      ram_drv = 1'b1;
    end
  end

  typedef struct {
    logic        port;
    logic        err;
    logic [63:0] rdata;
    int          cyc;
    logic [1:0]  drop;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] sb_mem [logic [63:0]];
  logic [63:0] m_rdata [2];
  logic        m_drives;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] a);
    return sb_mem.exists(a) ? sb_mem[a] : '0;
  endfunction

  // Push the expected completion of one access; base is its IDLE sample cycle
  task automatic expect_txn(input logic port, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input int base,
                            input logic [1:0] drop, output int cyc);
    exp_t e;
    int   lat;
    logic oor;
    oor = (addr >> LIMIT) != 0;
    if (oor) begin
      lat = 1;
    end else if (we) begin
      lat = m_drives ? 6 : 4;
      sb_mem[addr] = wdata;
      m_drives = 1'b0;
    end else begin
      lat = 4;
      m_rdata[port] = rd(addr);
      m_drives = 1'b1;
    end
    e.port  = port;
    e.err   = oor;
    e.rdata = m_rdata[port];
    e.cyc   = base + lat;
    e.drop  = drop;
    cyc     = e.cyc;
    sb.push_back(e);
  endtask

  // Called in the cycle-0 negedge; n counts cycles after that
  task automatic wait_acks(input int budget);
    int   n;
    logic prev_cs;
    exp_t e;
    n = 0;
    prev_cs = 1'b0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (ram_cs) chk("cs_width", prev_cs, 0);
      prev_cs = ram_cs;
      if (i_ack || d_ack) begin
        chk("ack_exclusive", i_ack & d_ack, 0);
        e = sb.pop_front();
        chk("ack_port", d_ack, e.port);
        chk("ack_cycle", n, e.cyc);
        chk("err", d_ack ? d_err : i_err, e.err);
        chk("rdata", d_ack ? d_rdata : i_rdata, e.rdata);
        if (e.drop[0]) i_req = 1'b0;
        if (e.drop[1]) d_req = 1'b0;
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ack_timeout", n, e.cyc);
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic txn(input logic port, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata);
    int c;
    @(negedge clk);
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    expect_txn(port, we, addr, wdata, 0, port ? 2'b10 : 2'b01, c);
    wait_acks(20);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_drives = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          c;
    int unsigned k;
    int          n;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_drives   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs", ram_cs, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_oe", ram_oe, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_i_err", i_err, 0);
    chk("rst_d_err", d_err, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    // Store through turnaround, then fetch it back
    txn(1'b1, 1'b1, 64'h100, 64'h0123_4567_89AB_CDEF);
    txn(1'b0, 1'b0, 64'h100, '0);
    // Store after load takes turnaround; store after store does not
    txn(1'b1, 1'b1, 64'h300, 64'hFEDC_BA98_7654_3210);
    txn(1'b1, 1'b1, 64'h308, 64'h1111_2222_3333_4444);

    // Contention from reset: I first, then alternating while both held
    apply_reset();
    @(negedge clk);
    i_req = 1'b1; i_addr = 64'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    expect_txn(1'b0, 1'b0, 64'h100, '0, 0, 2'b00, c);
    expect_txn(1'b1, 1'b0, 64'h300, '0, c + 1, 2'b00, c);
    expect_txn(1'b0, 1'b0, 64'h100, '0, c + 1, 2'b00, c);
    expect_txn(1'b1, 1'b0, 64'h300, '0, c + 1, 2'b11, c);
    wait_acks(40);

    // Store/load/store/load on one address
    txn(1'b1, 1'b1, 64'h200, 64'hAAAA_AAAA_AAAA_AAAA);
    txn(1'b1, 1'b0, 64'h200, '0);
    txn(1'b1, 1'b1, 64'h200, 64'h5555_5555_5555_5555);
    txn(1'b1, 1'b0, 64'h200, '0);

    // Range boundaries: out of range never strobes and leaves rdata alone
    k = cs_count;
    txn(1'b1, 1'b0, 64'h0000_0001_0000_0000, '0);
    chk("oor_no_strobe", cs_count, k);
    k = cs_count;
    txn(1'b0, 1'b0, 64'h0000_0000_1000_0000, '0);
    chk("oor_i_no_strobe", cs_count, k);
    txn(1'b1, 1'b0, 64'h0000_0000_0FFF_FFF8, '0);

    // Asynchronous reset in the middle of a store's real strobe
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h400; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    k = cs_count;
    n = 0;
    while (cs_count < k + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_strobe", ram_cs, 1);
    rst = 1'b1;
    #1;
    chk("abort_cs", ram_cs, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_oe", ram_oe, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_d_ack", d_ack, 0);
    chk("abort_i_rdata", i_rdata, 0);
    chk("abort_d_rdata", d_rdata, 0);
    d_req = 1'b0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_drives = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_ack_after_abort", d_ack, 0);
    end
    txn(1'b1, 1'b1, 64'h400, 64'hDEAD_BEEF_CAFE_F00D);
    txn(1'b0, 1'b0, 64'h400, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
